// File: rtl/masked_case_table.sv
// Run-time programmable casez-style decoder: ENTRIES match/care/data rules with
// lowest-index priority, a default on miss, multi-hit flagging and saturating stats.
module masked_case_table #(
   parameter int                SEL_W        = 2,
   parameter int                DATA_W       = 4,
   parameter int                ENTRIES      = 4,
   parameter int                IDX_W        = 2,
   parameter logic [DATA_W-1:0] DEFAULT_DATA = 4'h8,
   parameter int                CNT_W        = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_en,
   input  logic [SEL_W-1:0]  cfg_match,
   input  logic [SEL_W-1:0]  cfg_care,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SEL_W-1:0]  in_select,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_hit,
   output logic              out_multi,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  multi_count
);

   logic [ENTRIES-1:0]             hit;
   logic [ENTRIES-1:0][DATA_W-1:0] rule_data;

   // Indices at or beyond ENTRIES decode to no rule, so such writes fall away.
   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_rule
         logic              en_q, en_d;
         logic [SEL_W-1:0]  match_q, match_d;
         logic [SEL_W-1:0]  care_q, care_d;
         logic [DATA_W-1:0] data_q, data_d;

         always_comb begin
            en_d    = en_q;
            match_d = match_q;
            care_d  = care_q;
            data_d  = data_q;
            if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
               en_d    = cfg_en;
               match_d = cfg_match;
               care_d  = cfg_care;
               data_d  = cfg_data;
            end
         end

         always_ff @(posedge clock) begin
            if (!reset_n) begin
               en_q    <= 1'b0;
               match_q <= '0;
               care_q  <= '0;
               data_q  <= '0;
            end else begin
               en_q    <= en_d;
               match_q <= match_d;
               care_q  <= care_d;
               data_q  <= data_d;
            end
         end

         assign hit[gi]       = en_q && (((in_select ^ match_q) & care_q) == '0);
         assign rule_data[gi] = data_q;
      end
   endgenerate

   logic [DATA_W-1:0] lookup_data;
   logic              lookup_hit;
   logic              lookup_multi;

   // Walk from the top so the lowest-index hit is written last and wins.
   always_comb begin
      lookup_data = DEFAULT_DATA;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (hit[i]) lookup_data = rule_data[i];
      end
   end

   assign lookup_hit   = |hit;
   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign lookup_multi = (hit & (hit - ENTRIES'(1))) != '0;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_hit_q, out_hit_d;
   logic              out_multi_q, out_multi_d;
   logic [CNT_W-1:0]  miss_count_q, miss_count_d;
   logic [CNT_W-1:0]  multi_count_q, multi_count_d;
   logic              accept;

   assign in_ready = !reset_n || !out_valid_q || out_ready;
   assign accept   = reset_n && in_valid && in_ready;

   always_comb begin
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_hit_d     = out_hit_q;
      out_multi_d   = out_multi_q;
      miss_count_d  = miss_count_q;
      multi_count_d = multi_count_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = lookup_data;
         out_hit_d   = lookup_hit;
         out_multi_d = lookup_multi;
         if (!lookup_hit && (miss_count_q != '1))
            miss_count_d = miss_count_q + CNT_W'(1);
         if (lookup_multi && (multi_count_q != '1))
            multi_count_d = multi_count_q + CNT_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_hit_q     <= 1'b0;
         out_multi_q   <= 1'b0;
         miss_count_q  <= '0;
         multi_count_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_hit_q     <= out_hit_d;
         out_multi_q   <= out_multi_d;
         miss_count_q  <= miss_count_d;
         multi_count_q <= multi_count_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_hit     = out_hit_q;
   assign out_multi   = out_multi_q;
   assign miss_count  = miss_count_q;
   assign multi_count = multi_count_q;

endmodule

// File: tb/tb_masked_case_table.sv
// Bench for masked_case_table: constant vector tables, hand sequences for the
// handshake corners, and random traffic checked against a rule-list model.
module tb_masked_case_table;

   localparam int ENTRIES = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic       cfg_en;
   logic [1:0] cfg_match;
   logic [1:0] cfg_care;
   logic [3:0] cfg_data;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_select;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_hit;
   logic       out_multi;
   logic [7:0] miss_count;
   logic [7:0] multi_count;

   masked_case_table dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_en      (cfg_en),
      .cfg_match   (cfg_match),
      .cfg_care    (cfg_care),
      .cfg_data    (cfg_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_select   (in_select),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_hit     (out_hit),
      .out_multi   (out_multi),
      .miss_count  (miss_count),
      .multi_count (multi_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a plain rule list plus the expected output register.
   logic       m_en    [ENTRIES];
   logic [1:0] m_match [ENTRIES];
   logic [1:0] m_care  [ENTRIES];
   logic [3:0] m_data  [ENTRIES];
   logic       exp_valid;
   logic [3:0] exp_data;
   logic       exp_hit;
   logic       exp_multi;
   int         exp_miss_cnt;
   int         exp_multi_cnt;

   typedef struct {
      int         ph;
      logic [1:0] sel;
      logic [3:0] data;
      logic       hit;
      logic       multi;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_en[i] = 1'b0; m_match[i] = '0; m_care[i] = '0; m_data[i] = '0;
      end
      exp_valid = 1'b0; exp_data = '0; exp_hit = 1'b0; exp_multi = 1'b0;
      exp_miss_cnt = 0; exp_multi_cnt = 0;
   endtask

   task automatic model_lookup(input logic [1:0] sel, output logic [3:0] d,
                               output logic h, output logic m);
      int hits[$];
      for (int i = 0; i < ENTRIES; i++)
         if (m_en[i] && ((sel & m_care[i]) == (m_match[i] & m_care[i])))
            hits.push_back(i);
      d = (hits.size() > 0) ? m_data[hits[0]] : 4'h8;
      h = hits.size() > 0;
      m = hits.size() >= 2;
   endtask

   // One clock with the currently driven inputs; the model advances alongside.
   task automatic step();
      logic       exp_ready;
      logic [3:0] d;
      logic       h, m;
      #1;
      exp_ready = !exp_valid || out_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (in_valid && exp_ready) begin
         model_lookup(in_select, d, h, m);
         exp_valid = 1'b1; exp_data = d; exp_hit = h; exp_multi = m;
         if (!h && exp_miss_cnt < 255) exp_miss_cnt++;
         if (m && exp_multi_cnt < 255) exp_multi_cnt++;
         $display("lookup sel=%b -> expect data=%h hit=%0d multi=%0d", in_select, d, h, m);
      end else if (out_ready) begin
         exp_valid = 1'b0;
      end
      if (cfg_we && int'(cfg_idx) < ENTRIES) begin
         m_en[cfg_idx] = cfg_en; m_match[cfg_idx] = cfg_match;
         m_care[cfg_idx] = cfg_care; m_data[cfg_idx] = cfg_data;
      end
      @(posedge clock);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
         chk("out_data", {28'd0, out_data}, {28'd0, exp_data});
         chk("out_hit", {31'd0, out_hit}, {31'd0, exp_hit});
         chk("out_multi", {31'd0, out_multi}, {31'd0, exp_multi});
      end
      chk("miss_count", {24'd0, miss_count}, exp_miss_cnt);
      chk("multi_count", {24'd0, multi_count}, exp_multi_cnt);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; cfg_we = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
         @(posedge clock);
         #1;
      end
      model_reset();
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_data", {28'd0, out_data}, 32'd0);
      chk("reset_out_hit", {31'd0, out_hit}, 32'd0);
      chk("reset_out_multi", {31'd0, out_multi}, 32'd0);
      chk("reset_miss_count", {24'd0, miss_count}, 32'd0);
      chk("reset_multi_count", {24'd0, multi_count}, 32'd0);
      reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic write_rule(input int idx, input logic en, input logic [1:0] match,
                             input logic [1:0] care, input logic [3:0] data);
      in_valid = 1'b0; out_ready = 1'b1;
      cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en;
      cfg_match = match; cfg_care = care; cfg_data = data;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic program_phase(input int ph);
      for (int i = 0; i < ENTRIES; i++) write_rule(i, 1'b0, 2'b00, 2'b00, 4'h0);
      case (ph)
         0: begin
            write_rule(0, 1'b1, 2'b00, 2'b11, 4'ha);
            write_rule(1, 1'b1, 2'b01, 2'b11, 4'h6);
            write_rule(2, 1'b1, 2'b10, 2'b11, 4'h3);
         end
         1: begin
            write_rule(0, 1'b1, 2'b00, 2'b11, 4'h3);
            write_rule(1, 1'b1, 2'b10, 2'b10, 4'hd);
         end
         2: begin
            write_rule(0, 1'b1, 2'b10, 2'b10, 4'hd);
            write_rule(1, 1'b1, 2'b11, 2'b11, 4'h5);
         end
         default: begin
            write_rule(0, 1'b1, 2'b01, 2'b11, 4'hc);
            write_rule(3, 1'b1, 2'b00, 2'b00, 4'h2);
         end
      endcase
   endtask

   task automatic add_vec(input int ph, input logic [1:0] sel, input logic [3:0] data,
                          input logic hit, input logic multi);
      vec_t v;
      v.ph = ph; v.sel = sel; v.data = data; v.hit = hit; v.multi = multi;
      vecs.push_back(v);
   endtask

   initial begin
      int         cur_ph;
      int         saved_miss;
      int         saved_multi;
      logic [3:0] held;

      reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
      cfg_match = '0; cfg_care = '0; cfg_data = '0;
      in_valid = 1'b0; in_select = '0; out_ready = 1'b0;
      model_reset();

      add_vec(0, 2'b00, 4'ha, 1'b1, 1'b0);
      add_vec(0, 2'b01, 4'h6, 1'b1, 1'b0);
      add_vec(0, 2'b10, 4'h3, 1'b1, 1'b0);
      add_vec(0, 2'b11, 4'h8, 1'b0, 1'b0);
      add_vec(1, 2'b10, 4'hd, 1'b1, 1'b0);
      add_vec(1, 2'b11, 4'hd, 1'b1, 1'b0);
      add_vec(1, 2'b00, 4'h3, 1'b1, 1'b0);
      add_vec(1, 2'b01, 4'h8, 1'b0, 1'b0);
      add_vec(2, 2'b11, 4'hd, 1'b1, 1'b1);
      add_vec(2, 2'b10, 4'hd, 1'b1, 1'b0);
      add_vec(2, 2'b01, 4'h8, 1'b0, 1'b0);
      add_vec(3, 2'b01, 4'hc, 1'b1, 1'b1);
      add_vec(3, 2'b00, 4'h2, 1'b1, 1'b0);
      add_vec(3, 2'b10, 4'h2, 1'b1, 1'b0);

      // Reset, then a lookup into the empty table must miss.
      do_reset();
      in_valid = 1'b1; in_select = 2'b01;
      step();
      in_valid = 1'b0;
      chk("empty_table_data", {28'd0, out_data}, 32'h8);
      chk("empty_table_hit", {31'd0, out_hit}, 32'd0);
      chk("empty_table_miss_count", {24'd0, miss_count}, 32'd1);

      // Vector table, back-to-back lookups within each rule set.
      cur_ph = -1;
      foreach (vecs[k]) begin
         if (vecs[k].ph != cur_ph) begin
            cur_ph = vecs[k].ph;
            program_phase(cur_ph);
         end
         saved_multi = exp_multi_cnt;
         in_valid = 1'b1; out_ready = 1'b1; in_select = vecs[k].sel;
         step();
         in_valid = 1'b0;
         chk("vec_data", {28'd0, out_data}, {28'd0, vecs[k].data});
         chk("vec_hit", {31'd0, out_hit}, {31'd0, vecs[k].hit});
         chk("vec_multi", {31'd0, out_multi}, {31'd0, vecs[k].multi});
         chk("vec_multi_count", {24'd0, multi_count}, saved_multi + (vecs[k].multi ? 1 : 0));
      end

      // Backpressure: first result held for three stalled cycles.
      program_phase(0);
      out_ready = 1'b1; in_valid = 1'b0;
      step();
      out_ready = 1'b0; in_valid = 1'b1; in_select = 2'b01;
      step();
      held = out_data;
      chk("bp_first", {28'd0, held}, 32'h6);
      saved_miss = exp_miss_cnt;
      in_select = 2'b11;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_held_data", {28'd0, out_data}, 32'h6);
         chk("bp_miss_hold", {24'd0, miss_count}, saved_miss);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp_queued_data", {28'd0, out_data}, 32'h8);
      chk("bp_queued_miss", {24'd0, miss_count}, saved_miss + 1);

      // Same-cycle write: the lookup sees the old rule, the next one the new.
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1;
      cfg_match = 2'b00; cfg_care = 2'b11; cfg_data = 4'h7;
      in_valid = 1'b1; in_select = 2'b00;
      step();
      cfg_we = 1'b0;
      chk("same_cycle_old", {28'd0, out_data}, 32'ha);
      step();
      chk("same_cycle_new", {28'd0, out_data}, 32'h7);
      in_valid = 1'b0;

      // Saturation: 300 misses into an empty table.
      for (int i = 0; i < ENTRIES; i++) write_rule(i, 1'b0, 2'b00, 2'b00, 4'h0);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_select = 2'($urandom_range(0, 3));
         step();
      end
      in_valid = 1'b0;
      chk("miss_saturated", {24'd0, miss_count}, 32'd255);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cfg_we    = ($urandom_range(0, 3) == 0);
         cfg_idx   = 2'($urandom_range(0, 3));
         cfg_en    = ($urandom_range(0, 3) != 0);
         cfg_match = 2'($urandom_range(0, 3));
         cfg_care  = 2'($urandom_range(0, 3));
         cfg_data  = 4'($urandom_range(0, 15));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_select = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      cfg_we = 1'b0;

      // Reset with a result pending must discard it.
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
